// File: rtl/rec_play_ctrl.sv
// Record/playback controller for an SRAM audio recorder.
// It debounces four push keys and turns debounced presses into prioritised
// key events. A six-state FSM issues one-cycle recorder and player commands.
// The block also holds the playback speed factor and the DSP mode levels,
// and latches the length of the last recording.
module rec_play_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int MAX_SPEED  = 8,
    parameter int DEB_CYCLES = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_key_n,
    input  logic              i_sw_slow,
    input  logic              i_sw_interp,
    input  logic              i_init_done,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic              i_rec_full,
    input  logic              i_play_done,
    output logic [2:0]        o_state,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic [3:0]        o_speed,
    output logic              o_fast,
    output logic              o_slow_0,
    output logic              o_slow_1,
    output logic [ADDR_W-1:0] o_rec_len
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0] SPEED_MAX = 4'(MAX_SPEED);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        READY      = 3'd1,
        REC        = 3'd2,
        REC_PAUSE  = 3'd3,
        PLAY       = 3'd4,
        PLAY_PAUSE = 3'd5
    } state_t;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       evt_q;

    state_t           state_q, state_d;
    logic [5:0]       cmd_q, cmd_d;
    logic [3:0]       speed_q, speed_d;
    logic [2:0]       mode_q, mode_d;
    logic [ADDR_W-1:0] recLen_q, recLen_d;

    logic evStop, evRec, evPlay, evSpeed;

    // Two-flop synchroniser for the raw keys. Keys reset to the released level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level flips once DEB_CYCLES consecutive samples disagree with it.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state. A press event is a one-cycle pulse on a debounced high-to-low change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_q <= 4'hF;
            evt_q <= 4'h0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            evt_q <= deb_q & ~deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Priority filter: stop beats record, which beats play/pause, which beats speed.
    always_comb begin
        evStop  = evt_q[2];
        evRec   = evt_q[0] & ~evt_q[2];
        evPlay  = evt_q[1] & ~evt_q[2] & ~evt_q[0];
        evSpeed = evt_q[3] & ~evt_q[2] & ~evt_q[0] & ~evt_q[1];
    end

    // Next state, command pulses {recStart, recPause, recStop, playStart, playPause, playStop},
    // speed factor, recording length and DSP mode levels. Modes track the next state so
    // they align with o_state.
    always_comb begin
        state_d  = state_q;
        cmd_d    = 6'b000000;
        speed_d  = speed_q;
        recLen_d = recLen_q;
        mode_d   = 3'b000;

        case (state_q)
            INIT: begin
                if (i_init_done) state_d = READY;
            end
            READY: begin
                if (evRec) begin
                    state_d = REC;
                    cmd_d   = 6'b100000;
                end else if (evPlay && (recLen_q != '0)) begin
                    state_d = PLAY;
                    cmd_d   = 6'b000100;
                end
            end
            REC: begin
                if (evStop || i_rec_full) begin
                    state_d  = READY;
                    cmd_d    = 6'b001000;
                    recLen_d = i_rec_addr;
                end else if (evRec) begin
                    state_d = REC_PAUSE;
                    cmd_d   = 6'b010000;
                end
            end
            REC_PAUSE: begin
                if (evStop) begin
                    state_d  = READY;
                    cmd_d    = 6'b001000;
                    recLen_d = i_rec_addr;
                end else if (evRec) begin
                    state_d = REC;
                    cmd_d   = 6'b100000;
                end
            end
            PLAY: begin
                if (evStop || i_play_done) begin
                    state_d = READY;
                    cmd_d   = 6'b000001;
                end else if (evPlay) begin
                    state_d = PLAY_PAUSE;
                    cmd_d   = 6'b000010;
                end
            end
            PLAY_PAUSE: begin
                if (evStop) begin
                    state_d = READY;
                    cmd_d   = 6'b000001;
                end else if (evPlay) begin
                    state_d = PLAY;
                    cmd_d   = 6'b000100;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase

        if (evSpeed && (state_q != INIT)) begin
            speed_d = (speed_q >= SPEED_MAX) ? 4'd1 : speed_q + 4'd1;
        end

        if ((state_d == PLAY) && (speed_d > 4'd1)) begin
            mode_d = {~i_sw_slow, i_sw_slow & ~i_sw_interp, i_sw_slow & i_sw_interp};
        end
    end

    // Control registers. Reset aborts any activity without issuing a command.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= INIT;
            cmd_q    <= 6'b000000;
            speed_q  <= 4'd1;
            mode_q   <= 3'b000;
            recLen_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            speed_q  <= speed_d;
            mode_q   <= mode_d;
            recLen_q <= recLen_d;
        end
    end

    assign o_state      = state_q;
    assign o_rec_start  = cmd_q[5];
    assign o_rec_pause  = cmd_q[4];
    assign o_rec_stop   = cmd_q[3];
    assign o_play_start = cmd_q[2];
    assign o_play_pause = cmd_q[1];
    assign o_play_stop  = cmd_q[0];
    assign o_speed      = speed_q;
    assign o_fast       = mode_q[2];
    assign o_slow_0     = mode_q[1];
    assign o_slow_1     = mode_q[0];
    assign o_rec_len    = recLen_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl: table of key steps plus corner sequences,
// command pulses checked against a scoreboard queue.
module tb_rec_play_ctrl;

    localparam int DEB = 64;
    localparam int AW  = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    keyN;
    logic          swSlow, swInterp, initDone, recFull, playDone;
    logic [AW-1:0] recAddr;
    logic [2:0]    state;
    logic          recStart, recPause, recStop, playStart, playPause, playStop;
    logic [3:0]    speed;
    logic          fast, slow0, slow1;
    logic [AW-1:0] recLen;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] pulses;
    } exp_t;

    exp_t expQ[$];

    typedef struct {
        logic [3:0]    keys;
        logic          slow;
        logic          interp;
        logic [AW-1:0] addr;
        logic [2:0]    st;
        logic [5:0]    pulses;
        logic [3:0]    spd;
        logic [2:0]    modes;
        logic [AW-1:0] len;
    } vec_t;

    vec_t vecs[16];

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_RS   = 6'b100000;
    localparam logic [5:0] P_RP   = 6'b010000;
    localparam logic [5:0] P_RX   = 6'b001000;
    localparam logic [5:0] P_PS   = 6'b000100;
    localparam logic [5:0] P_PP   = 6'b000010;
    localparam logic [5:0] P_PX   = 6'b000001;

    rec_play_ctrl #(.ADDR_W(AW), .MAX_SPEED(8), .DEB_CYCLES(DEB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_n(keyN), .i_sw_slow(swSlow),
        .i_sw_interp(swInterp), .i_init_done(initDone), .i_rec_addr(recAddr),
        .i_rec_full(recFull), .i_play_done(playDone), .o_state(state),
        .o_rec_start(recStart), .o_rec_pause(recPause), .o_rec_stop(recStop),
        .o_play_start(playStart), .o_play_pause(playPause), .o_play_stop(playStop),
        .o_speed(speed), .o_fast(fast), .o_slow_0(slow0), .o_slow_1(slow1),
        .o_rec_len(recLen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Press the keys in mask long enough to be accepted, then release them.
    task automatic applyStimulus(input logic [3:0] mask);
        @(negedge clk);
        keyN = ~mask;
        repeat (DEB + 8) @(negedge clk);
        keyN = 4'hF;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic pushExp(input logic [2:0] st, input logic [5:0] p);
        exp_t e;
        e.st = st;
        e.pulses = p;
        expQ.push_back(e);
    endtask

    // Every command pulse seen must match the oldest expected entry.
    always @(negedge clk) begin
        logic [5:0] seen;
        exp_t e;
        seen = {recStart, recPause, recStop, playStart, playPause, playStop};
        if (rst_n && seen != 6'b0) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: got %b state %0d expected none at %0t", seen, state, $time);
            end else begin
                e = expQ.pop_front();
                if (e.pulses != seen || e.st != state) begin
                    errors++;
                    $display("[TB] FAIL pulse: got %b/state %0d expected %b/state %0d at %0t",
                             seen, state, e.pulses, e.st, $time);
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 20'h00100, 3'd2, P_RS,   4'd1, 3'b000, 20'h00000};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 20'h00100, 3'd3, P_RP,   4'd1, 3'b000, 20'h00000};
        vecs[2]  = '{4'b0001, 1'b0, 1'b0, 20'h00100, 3'd2, P_RS,   4'd1, 3'b000, 20'h00000};
        vecs[3]  = '{4'b0100, 1'b0, 1'b0, 20'h00100, 3'd1, P_RX,   4'd1, 3'b000, 20'h00100};
        vecs[4]  = '{4'b0010, 1'b0, 1'b0, 20'h00100, 3'd4, P_PS,   4'd1, 3'b000, 20'h00100};
        vecs[5]  = '{4'b1000, 1'b0, 1'b0, 20'h00100, 3'd4, P_NONE, 4'd2, 3'b100, 20'h00100};
        vecs[6]  = '{4'b0010, 1'b0, 1'b0, 20'h00100, 3'd5, P_PP,   4'd2, 3'b000, 20'h00100};
        vecs[7]  = '{4'b0010, 1'b0, 1'b0, 20'h00100, 3'd4, P_PS,   4'd2, 3'b100, 20'h00100};
        vecs[8]  = '{4'b1000, 1'b1, 1'b1, 20'h00100, 3'd4, P_NONE, 4'd3, 3'b001, 20'h00100};
        vecs[9]  = '{4'b0110, 1'b1, 1'b1, 20'h00100, 3'd1, P_PX,   4'd3, 3'b000, 20'h00100};
        vecs[10] = '{4'b1000, 1'b1, 1'b1, 20'h00100, 3'd1, P_NONE, 4'd4, 3'b000, 20'h00100};
        vecs[11] = '{4'b0001, 1'b1, 1'b1, 20'h00200, 3'd2, P_RS,   4'd4, 3'b000, 20'h00100};
        vecs[12] = '{4'b1011, 1'b1, 1'b1, 20'h00200, 3'd3, P_RP,   4'd4, 3'b000, 20'h00100};
        vecs[13] = '{4'b0100, 1'b1, 1'b1, 20'h00200, 3'd1, P_RX,   4'd4, 3'b000, 20'h00200};
        vecs[14] = '{4'b1001, 1'b1, 1'b1, 20'h00200, 3'd2, P_RS,   4'd4, 3'b000, 20'h00200};
        vecs[15] = '{4'b0100, 1'b1, 1'b1, 20'h00300, 3'd1, P_RX,   4'd4, 3'b000, 20'h00300};

        keyN = 4'hF; swSlow = 1'b0; swInterp = 1'b0; initDone = 1'b0;
        recFull = 1'b0; playDone = 1'b0; recAddr = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_speed", 32'(speed), 32'd1);
        checkOutput("reset_len", 32'(recLen), 32'd0);
        checkOutput("reset_cmds", 32'({recStart, recPause, recStop, playStart, playPause, playStop}), 32'd0);
        checkOutput("reset_modes", 32'({fast, slow0, slow1}), 32'd0);
        rst_n = 1'b1;

        // Keys are ignored while the codec is initialising.
        applyStimulus(4'b1001);
        checkOutput("init_hold_state", 32'(state), 32'd0);
        checkOutput("init_hold_speed", 32'(speed), 32'd1);
        initDone = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("init_exit", 32'(state), 32'd1);

        // Play with nothing recorded is ignored.
        applyStimulus(4'b0010);
        checkOutput("empty_play", 32'(state), 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            swSlow = vecs[i].slow;
            swInterp = vecs[i].interp;
            recAddr = vecs[i].addr;
            if (vecs[i].pulses != P_NONE) pushExp(vecs[i].st, vecs[i].pulses);
            applyStimulus(vecs[i].keys);
            checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            checkOutput($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].spd));
            checkOutput($sformatf("vec%0d_modes", i), 32'({fast, slow0, slow1}), 32'(vecs[i].modes));
            checkOutput($sformatf("vec%0d_len", i), 32'(recLen), 32'(vecs[i].len));
            checkOutput($sformatf("vec%0d_pending", i), 32'(expQ.size()), 32'd0);
        end

        // Playback ended by the player, with a mode switch change on the way.
        pushExp(3'd4, P_PS);
        applyStimulus(4'b0010);
        checkOutput("pd_play_modes", 32'({fast, slow0, slow1}), 32'b001);
        @(negedge clk);
        swInterp = 1'b0;
        #1;
        checkOutput("sw_latency_old", 32'({fast, slow0, slow1}), 32'b001);
        @(negedge clk);
        checkOutput("sw_latency_new", 32'({fast, slow0, slow1}), 32'b010);
        pushExp(3'd1, P_PX);
        playDone = 1'b1;
        repeat (3) @(negedge clk);
        playDone = 1'b0;
        checkOutput("pd_state", 32'(state), 32'd1);
        checkOutput("pd_modes", 32'({fast, slow0, slow1}), 32'd0);
        checkOutput("pd_pending", 32'(expQ.size()), 32'd0);

        // Recording ended by a full SRAM.
        pushExp(3'd2, P_RS);
        applyStimulus(4'b0001);
        pushExp(3'd1, P_RX);
        recAddr = 20'hFFFFF;
        recFull = 1'b1;
        repeat (3) @(negedge clk);
        recFull = 1'b0;
        checkOutput("full_state", 32'(state), 32'd1);
        checkOutput("full_len", 32'(recLen), 32'hFFFFF);
        checkOutput("full_pending", 32'(expQ.size()), 32'd0);

        // Bouncing record key: short stable intervals never accepted, then one press.
        pushExp(3'd2, P_RS);
        for (int t = 0; t < 32; t++) begin
            keyN[0] = t[0];
            repeat (DEB / 4) @(negedge clk);
        end
        keyN[0] = 1'b0;
        repeat (3 * DEB) @(negedge clk);
        keyN[0] = 1'b1;
        repeat (3 * DEB) @(negedge clk);
        checkOutput("bounce_state", 32'(state), 32'd2);
        checkOutput("bounce_pending", 32'(expQ.size()), 32'd0);
        checkOutput("bounce_len_kept", 32'(recLen), 32'hFFFFF);
        recAddr = 20'h00400;
        pushExp(3'd1, P_RX);
        applyStimulus(4'b0100);
        checkOutput("bounce_stop_len", 32'(recLen), 32'h00400);

        // Asynchronous reset in the middle of playback, between clock edges.
        pushExp(3'd4, P_PS);
        applyStimulus(4'b0010);
        checkOutput("pre_rst_modes", 32'({fast, slow0, slow1}), 32'b010);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_speed", 32'(speed), 32'd1);
        checkOutput("arst_len", 32'(recLen), 32'd0);
        checkOutput("arst_modes", 32'({fast, slow0, slow1}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("arst_ready", 32'(state), 32'd1);
        applyStimulus(4'b0010);
        checkOutput("arst_empty_play", 32'(state), 32'd1);

        // Speed steps 2..8 then wraps to 1.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(4'b1000);
            checkOutput($sformatf("speed_step%0d", k), 32'(speed), (k < 8) ? 32'(k + 1) : 32'd1);
        end
        checkOutput("final_pending", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rec_play_ctrl.md
REC_PLAY_CTRL -- requirements
Module: rec_play_ctrl

Interface
REQ-001 Parameter: ADDR_W, 20, width of SRAM sample address.
REQ-002 Parameter: MAX_SPEED, 8, highest speed factor; legal range 2..15.
REQ-003 Parameter: DEB_CYCLES, 4096, consecutive stable cycles required to accept a key level; minimum 2.
REQ-004 Port: i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 Port: i_key_n  in  4  raw active-low push keys: [0] record, [1] play/pause, [2] stop, [3] speed step.
REQ-007 Port: i_sw_slow  in  1  speed direction: 0 fast, 1 slow.
REQ-008 Port: i_sw_interp  in  1  slow-mode interpolation: 0 constant, 1 linear.
REQ-009 Port: i_init_done  in  1  codec initialisation finished (level).
REQ-010 Port: i_rec_addr  in  ADDR_W  current recorder write address.
REQ-011 Port: i_rec_full  in  1  recorder reached last SRAM address (level).
REQ-012 Port: i_play_done  in  1  player reached end of recorded data (level).
REQ-013 Port: o_state  out  3  current state encoding (§Function).
REQ-014 Port: o_rec_start, o_rec_pause, o_rec_stop  out  1 each  single-cycle recorder commands.
REQ-015 Port: o_play_start, o_play_pause, o_play_stop  out  1 each  single-cycle player commands.
REQ-016 Port: o_speed  out  4  current speed factor, 1..MAX_SPEED.
REQ-017 Port: o_fast, o_slow_0, o_slow_1  out  1 each  DSP mode levels; at most one high.
REQ-018 Port: o_rec_len  out  ADDR_W  latched end address of last recording.

Function
REQ-019 Each key: 2-flop synchroniser, then debounce counter; debounced level changes only after DEB_CYCLES identical synchronised samples.
REQ-020 Key event = one-cycle pulse on debounced press (high->low of key_n); release produces no event.
REQ-021 Simultaneous events same cycle: priority stop > record > play/pause > speed; lower-priority events that cycle discarded.
REQ-022 States: INIT=0, READY=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5; codes 6,7 unreachable, recover to READY next cycle.
REQ-023 INIT -> READY when i_init_done=1; all key events ignored in INIT.
REQ-024 READY: record -> REC, pulse o_rec_start; play -> PLAY, pulse o_play_start, only if o_rec_len!=0, else ignored.
REQ-025 REC: record -> REC_PAUSE, pulse o_rec_pause; stop or i_rec_full=1 -> READY, pulse o_rec_stop, latch o_rec_len<=i_rec_addr.
REQ-026 REC_PAUSE: record -> REC, pulse o_rec_start; stop -> READY, pulse o_rec_stop, latch o_rec_len.
REQ-027 PLAY: play -> PLAY_PAUSE, pulse o_play_pause; stop or i_play_done=1 -> READY, pulse o_play_stop.
REQ-028 PLAY_PAUSE: play -> PLAY, pulse o_play_start; stop -> READY, pulse o_play_stop.
REQ-029 Command pulses registered: asserted exactly one cycle, in the cycle the new state is first visible on o_state.
REQ-030 Speed event in any state except INIT: o_speed increments; MAX_SPEED wraps to 1.
REQ-031 o_fast = (o_speed>1)&!i_sw_slow; o_slow_0 = (o_speed>1)&i_sw_slow&!i_sw_interp; o_slow_1 = (o_speed>1)&i_sw_slow&i_sw_interp; registered, one-cycle latency from switch change.
REQ-032 Mode outputs forced 0 when state is not PLAY; o_speed retains value.
REQ-033 o_rec_len held until next recording ends; starting a new recording does not clear it.

Reset
REQ-034 On i_rst_n=0, immediately: state INIT, all command pulses 0, o_fast/o_slow_0/o_slow_1 0, o_speed 1, o_rec_len 0, debounced levels released, counters 0.
REQ-035 Reset mid-record or mid-play aborts without stop pulse; no command issued until a fresh key event after INIT exits.

Verification
REQ-036 Bounce: key[0] toggling every 100 cycles for 2000 cycles, then low 5000 (DEB_CYCLES=4096) in READY -> exactly one o_rec_start, state 2.
REQ-037 Record full: in REC, i_rec_addr=20'hFFFFF, i_rec_full=1 -> o_rec_stop one cycle, state 1, o_rec_len=20'hFFFFF.
REQ-038 Empty play: after reset and init, press key[1] -> no o_play_start, state stays 1.
REQ-039 Simultaneous key[2]+key[1] in PLAY -> o_play_stop only, state 1, no o_play_pause.
REQ-040 Speed: MAX_SPEED=8, 8 key[3] presses -> o_speed 2..8 then 1; in PLAY with i_sw_slow=1, i_sw_interp=1 at speed 3 -> o_slow_1=1, others 0.
REQ-041 Async reset asserted mid-PLAY, off clock edge -> o_state=0, o_speed=1, o_rec_len=0 before next edge.
